// File: rtl/day11_route_combiner.sv
// Streaming route combiner: beat 0 is the part-1 count, then SEGS-beat groups are multiplied
// and summed per route into part2. Optional OVERFLOW_DETECT_EN adds a sticky overflow flag.
module day11_route_combiner #(
   parameter int WIDTH  = 64,
   parameter int SEGS   = 3,
   parameter int ROUTES = 2,
   parameter int IW     = $clog2(ROUTES*SEGS+2)
) (
   input  logic             clock,
   input  logic             clear_n,
   input  logic             load,
   input  logic [WIDTH-1:0] count,
   input  logic             count_valid,
   input  logic             count_last,
   output logic             ready,
   output logic             done_,
   output logic [WIDTH-1:0] part1_result,
   output logic [WIDTH-1:0] part2_result,
   output logic [IW-1:0]    idx,
   output logic             len_err,
   output logic             overflow,
   output logic             state_dbg
);

   localparam int T  = 1 + ROUTES*SEGS;
   localparam int SW = (SEGS > 1) ? $clog2(SEGS) : 1;
   localparam int RW = $clog2(ROUTES+1);
   localparam logic [IW-1:0] T_IDX     = IW'(T);
   localparam logic [IW-1:0] T_LAST    = IW'(T-1);
   localparam logic [SW-1:0] SEG_LAST  = SW'(SEGS-1);
   localparam logic [RW-1:0] ROUTE_MAX = RW'(ROUTES);

   typedef enum logic {COLLECT = 1'b0, DONE = 1'b1} state_t;
   state_t state_q, state_d;

   logic [WIDTH-1:0] prod_q;
   logic [SW-1:0]    seg_q;
   logic [RW-1:0]    route_q;
   logic [WIDTH-1:0] mul_lo, next_prod, part2_sum;
   logic             accept, first_beat, full, seg_first, seg_end, add_route;

   // valid/ready: a beat transfers on an edge where ready & count_valid are high and load is low.
   assign ready      = (state_q == COLLECT);
   assign done_      = (state_q == DONE);
   assign state_dbg  = state_q;
   assign accept     = ready & count_valid & ~load;
   assign first_beat = (idx == '0);
   assign full       = (idx == T_IDX);
   assign seg_first  = (seg_q == '0);
   assign seg_end    = (seg_q == SEG_LAST);
   assign add_route  = seg_end && (route_q < ROUTE_MAX);

`ifdef OVERFLOW_DETECT_EN
   logic [2*WIDTH-1:0] mul_full;
   logic [WIDTH:0]     sum_full;
   logic               ovf_hit;
   assign mul_full  = {{WIDTH{1'b0}}, prod_q} * {{WIDTH{1'b0}}, count};
   assign mul_lo    = mul_full[WIDTH-1:0];
   assign sum_full  = {1'b0, part2_result} + {1'b0, next_prod};
   assign part2_sum = sum_full[WIDTH-1:0];
   assign ovf_hit   = accept && !full && !first_beat &&
                      ((!seg_first && (|mul_full[2*WIDTH-1:WIDTH])) || (add_route && sum_full[WIDTH]));

   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n)     overflow <= 1'b0;
      else if (load)    overflow <= 1'b0;
      else if (ovf_hit) overflow <= 1'b1;
   end
`else
   assign mul_lo    = prod_q * count;
   assign part2_sum = part2_result + next_prod;
   assign overflow  = 1'b0;
`endif

   // The first segment of a route seeds the running product instead of multiplying.
   assign next_prod = seg_first ? count : mul_lo;

   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) state_q <= COLLECT;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         COLLECT: if (accept && count_last) state_d = DONE;
         DONE:    state_d = DONE;
         default: state_d = COLLECT;
      endcase
      if (load) state_d = COLLECT;
   end

   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         part1_result <= '0;
         part2_result <= '0;
         idx          <= '0;
         prod_q       <= '0;
         seg_q        <= '0;
         route_q      <= '0;
         len_err      <= 1'b0;
      end else if (load) begin
         part1_result <= '0;
         part2_result <= '0;
         idx          <= '0;
         prod_q       <= '0;
         seg_q        <= '0;
         route_q      <= '0;
         len_err      <= 1'b0;
      end else if (accept) begin
         if (full) begin
            len_err <= 1'b1;
         end else begin
            idx <= idx + 1'b1;
            if (first_beat) begin
               part1_result <= count;
            end else begin
               prod_q <= next_prod;
               if (seg_end) begin
                  if (add_route) part2_result <= part2_sum;
                  seg_q   <= '0;
                  route_q <= route_q + 1'b1;
               end else begin
                  seg_q <= seg_q + 1'b1;
               end
            end
         end
         // A last beat anywhere but the final slot marks the stream length as wrong.
         if (count_last && (idx != T_LAST)) len_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_day11_route_combiner.sv
// Directed bench for day11_route_combiner: a table of whole streams plus hand-written
// sequences for load-during-beat, async clear mid-cycle and valid held in DONE.
module tb_day11_route_combiner;

   logic        clock = 1'b0;
   logic        clear_n, load, count_valid, count_last;
   logic [63:0] count;
   logic        ready, done_, len_err, overflow, state_dbg;
   logic [63:0] part1_result, part2_result;
   logic [2:0]  idx;

   int n_cmp = 0;
   int n_err = 0;

`ifdef OVERFLOW_DETECT_EN
   localparam logic OVF_ON = 1'b1;
`else
   localparam logic OVF_ON = 1'b0;
`endif

   day11_route_combiner dut (
      .clock(clock), .clear_n(clear_n), .load(load), .count(count),
      .count_valid(count_valid), .count_last(count_last), .ready(ready), .done_(done_),
      .part1_result(part1_result), .part2_result(part2_result), .idx(idx),
      .len_err(len_err), .overflow(overflow), .state_dbg(state_dbg)
   );

   always #5 clock = ~clock;

   typedef struct {
      string            name;
      int               n;
      logic [7:0][63:0] beats;
      logic [63:0]      e_p1;
      logic [63:0]      e_p2;
      logic [63:0]      e_idx;
      logic             e_le;
      logic             e_ovf;
   } vec_t;

   vec_t vecs[8];
   int   nv = 0;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic add_vec(input string nm, input int n,
                          input logic [63:0] b0, b1, b2, b3, b4, b5, b6, b7,
                          input logic [63:0] p1, p2, input logic [63:0] ix,
                          input logic le, input logic ov);
      vecs[nv].name  = nm;
      vecs[nv].n     = n;
      vecs[nv].beats[0] = b0; vecs[nv].beats[1] = b1; vecs[nv].beats[2] = b2;
      vecs[nv].beats[3] = b3; vecs[nv].beats[4] = b4; vecs[nv].beats[5] = b5;
      vecs[nv].beats[6] = b6; vecs[nv].beats[7] = b7;
      vecs[nv].e_p1  = p1;
      vecs[nv].e_p2  = p2;
      vecs[nv].e_idx = ix;
      vecs[nv].e_le  = le;
      vecs[nv].e_ovf = ov;
      nv++;
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic pulse_load();
      load = 1'b1; count_valid = 1'b0; count_last = 1'b0;
      tick();
      load = 1'b0;
   endtask

   task automatic drive_beat(input logic [63:0] v, input logic last);
      count = v; count_valid = 1'b1; count_last = last;
      tick();
      count_valid = 1'b0; count_last = 1'b0;
   endtask

   task automatic check_all(input string pfx, input logic [63:0] p1, input logic [63:0] p2,
                            input logic [63:0] ix, input logic le, input logic dn,
                            input logic ov);
      check({pfx, ".part1"},   part1_result, p1);
      check({pfx, ".part2"},   part2_result, p2);
      check({pfx, ".idx"},     {61'd0, idx}, ix);
      check({pfx, ".len_err"}, {63'd0, len_err}, {63'd0, le});
      check({pfx, ".done"},    {63'd0, done_}, {63'd0, dn});
      check({pfx, ".ready"},   {63'd0, ready}, {63'd0, ~dn});
      check({pfx, ".ovf"},     {63'd0, overflow}, {63'd0, ov});
   endtask

   initial begin
      logic [63:0] m1;
      m1 = '1;
      add_vec("basic", 7, 5, 2, 3, 4, 1, 6, 7, 0, 5, 66, 7, 1'b0, 1'b0);
      add_vec("short", 3, 5, 2, 3, 0, 0, 0, 0, 0, 5, 0, 3, 1'b1, 1'b0);
      add_vec("long",  8, 5, 2, 3, 4, 1, 6, 7, 9, 5, 66, 7, 1'b1, 1'b0);
      add_vec("wrap32", 7, 0, 64'h1_0000_0000, 64'h1_0000_0000, 1, 1, 1, 1, 0, 0, 1, 7, 1'b0, OVF_ON);
      add_vec("mixed", 7, 10, 1, 1, 1, 2, 2, 2, 0, 10, 9, 7, 1'b0, 1'b0);
      add_vec("sumwrap", 7, 9, m1, m1, 1, m1, 1, 1, 0, 9, 0, 7, 1'b0, OVF_ON);
      add_vec("single", 1, 42, 0, 0, 0, 0, 0, 0, 0, 42, 0, 1, 1'b1, 1'b0);

      clear_n = 1'b0; load = 1'b0; count = '0; count_valid = 1'b0; count_last = 1'b0;
      tick(); tick();
      check_all("reset", 0, 0, 0, 1'b0, 1'b0, 1'b0);
      clear_n = 1'b1;
      tick();

      // Table of whole streams, each started with a load pulse.
      for (int k = 0; k < nv; k++) begin
         pulse_load();
         check({vecs[k].name, ".load_idx"}, {61'd0, idx}, 0);
         check({vecs[k].name, ".load_p2"}, part2_result, 0);
         for (int i = 0; i < vecs[k].n; i++)
            drive_beat(vecs[k].beats[i], i == vecs[k].n - 1);
         check_all(vecs[k].name, vecs[k].e_p1, vecs[k].e_p2, vecs[k].e_idx,
                   vecs[k].e_le, 1'b1, vecs[k].e_ovf);
      end

      // load with a valid beat in the same cycle: the beat is dropped, state zeroed.
      pulse_load();
      drive_beat(5, 1'b0); drive_beat(2, 1'b0); drive_beat(3, 1'b0); drive_beat(4, 1'b0);
      check("pre_load.part2", part2_result, 24);
      load = 1'b1; count = 99; count_valid = 1'b1; count_last = 1'b1;
      tick();
      load = 1'b0; count_valid = 1'b0; count_last = 1'b0;
      check_all("load_drop", 0, 0, 0, 1'b0, 1'b0, 1'b0);
      drive_beat(5, 1'b0); drive_beat(2, 1'b0); drive_beat(3, 1'b0); drive_beat(4, 1'b0);
      drive_beat(1, 1'b0); drive_beat(6, 1'b0); drive_beat(7, 1'b1);
      check_all("replay", 5, 66, 7, 1'b0, 1'b1, 1'b0);

      // Valid held while in DONE must not be accepted.
      count = 77; count_valid = 1'b1; count_last = 1'b1;
      tick(); tick(); tick();
      count_valid = 1'b0; count_last = 1'b0;
      check_all("done_hold", 5, 66, 7, 1'b0, 1'b1, 1'b0);

      // Async clear mid-cycle after beat 3 clears outputs before the next edge.
      pulse_load();
      drive_beat(5, 1'b0); drive_beat(2, 1'b0); drive_beat(3, 1'b0);
      check("pre_clr.idx", {61'd0, idx}, 3);
      #2 clear_n = 1'b0;
      #1;
      check_all("async_clr", 0, 0, 0, 1'b0, 1'b0, 1'b0);
      clear_n = 1'b1;
      tick();
      drive_beat(8, 1'b1);
      check_all("after_clr", 8, 0, 1, 1'b1, 1'b1, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
